// File: rtl/div_pkg.sv
// Shared widths and constants for the pipelined linear-vectoring CORDIC divider.
package div_pkg;
   localparam int W     = 8;
   localparam int ITERS = 8;
   localparam int GUARD = 8;
   localparam int XW    = 16;
   localparam int YW    = 19;
   localparam int ZW    = 9;

   localparam logic [ZW-1:0] ONE_Q17 = 9'd128;
endpackage

// File: rtl/cordic_lin_stage.sv
// One linear-vectoring CORDIC iteration with its pipeline register.
// The last stage also converts the non-restoring quotient into a floor.
module cordic_lin_stage
   import div_pkg::*;
#(
   parameter int SHIFT = 0,
   parameter bit LAST  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [XW-1:0]        x_i,
   input  logic signed [YW-1:0] y_i,
   input  logic signed [ZW-1:0] z_i,
   output logic [XW-1:0]        x_o,
   output logic signed [YW-1:0] y_o,
   output logic signed [ZW-1:0] z_o
);

   localparam logic signed [ZW-1:0] STEP = signed'(ONE_Q17 >> SHIFT);

   logic signed [YW-1:0] x_shift;
   logic signed [YW-1:0] y_d;
   logic signed [ZW-1:0] z_step;
   logic signed [ZW-1:0] z_d;

   logic [XW-1:0]        x_q;
   logic signed [YW-1:0] y_q;
   logic signed [ZW-1:0] z_q;

   // The low GUARD bits of x are zero, so this shift never drops a one.
   assign x_shift = signed'({{(YW-XW){1'b0}}, x_i >> SHIFT});

   always_comb begin
      y_d    = y_i;
      z_step = z_i;
      if (!y_i[YW-1]) begin
         y_d    = y_i - x_shift;
         z_step = z_i + STEP;
      end else begin
         y_d    = y_i + x_shift;
         z_step = z_i - STEP;
      end
      z_d = z_step;
      // A negative remainder means the last digit overshot by one LSB.
      if (LAST && y_d[YW-1]) begin
         z_d = z_step - 9'sd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
         z_q <= '0;
      end else begin
         x_q <= x_i;
         y_q <= y_d;
         z_q <= z_d;
      end
   end

   assign x_o = x_q;
   assign y_o = y_q;
   assign z_o = z_q;

endmodule

// File: rtl/div.sv
// Free-running pipelined divider: C = min(255, floor(128*A/B)), 8-cycle latency.
// Operands enter stage 0 straight from the ports every clock.
module div
   import div_pkg::*;
(
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         clk,
   input  logic         rst,
   output logic [W-1:0] C
);

   logic [XW-1:0]        x_s [ITERS+1];
   logic signed [YW-1:0] y_s [ITERS+1];
   logic signed [ZW-1:0] z_s [ITERS+1];

   assign x_s[0] = {B, {GUARD{1'b0}}};
   assign y_s[0] = signed'({{(YW-W-GUARD){1'b0}}, A, {GUARD{1'b0}}});
   assign z_s[0] = '0;

   generate
      for (genvar gi = 0; gi < ITERS; gi++) begin : g_stage
         cordic_lin_stage #(
            .SHIFT(gi),
            .LAST (gi == ITERS-1)
         ) u_stage (
            .clk(clk),
            .rst(rst),
            .x_i(x_s[gi]),
            .y_i(y_s[gi]),
            .z_i(z_s[gi]),
            .x_o(x_s[gi+1]),
            .y_o(y_s[gi+1]),
            .z_o(z_s[gi+1])
         );
      end
   endgenerate

   // After correction z lies in [0,255], so its sign bit carries no information.
   assign C = z_s[ITERS][W-1:0];

   logic unused_tail;
   assign unused_tail = ^{x_s[ITERS], y_s[ITERS], z_s[ITERS][ZW-1]};

endmodule

// File: tb/tb_div.sv
// Directed and randomised checks of the pipelined divider.
module tb_div;

   logic       clk;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] c;

   int errors = 0;
   int checks = 0;

   div u_dut (
      .A  (a),
      .B  (b),
      .clk(clk),
      .rst(rst),
      .C  (c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ref_div(input logic [7:0] aa, input logic [7:0] bb);
      int q;
      if (bb == 8'd0) return 8'hFF;
      q = (128 * int'(aa)) / int'(bb);
      if (q > 255) return 8'hFF;
      return q[7:0];
   endfunction

   task automatic hold(input logic [7:0] av, input logic [7:0] bv);
      a = av;
      b = bv;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a   = 8'd7;
      b   = 8'd49;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (c !== 8'h00) begin
            errors++;
            $display("FAIL reset_edge%0d: C=%h required=00", i, c);
         end else $display("reset_edge%0d: C=%h ok", i, c);
      end
      rst = 1'b0;
      hold(8'd7, 8'd49);
      checks++;
      if (c !== 8'h12) begin
         errors++;
         $display("FAIL reset_refill 7/49: C=%h required=12", c);
      end else $display("reset_refill 7/49: C=%h ok", c);
   endtask

   task automatic test_basic();
      logic [7:0] va[3] = '{8'd49, 8'd255, 8'd1};
      logic [7:0] vb[3] = '{8'd49, 8'd200, 8'd255};
      logic [7:0] ve[3] = '{8'h80, 8'hA3, 8'h00};
      for (int i = 0; i < 3; i++) begin
         hold(va[i], vb[i]);
         checks++;
         if (c !== ve[i]) begin
            errors++;
            $display("FAIL basic %0d/%0d: C=%h required=%h", va[i], vb[i], c, ve[i]);
         end else $display("basic %0d/%0d: C=%h ok", va[i], vb[i], c);
      end
   endtask

   task automatic test_saturate();
      logic [7:0] va[3] = '{8'd100, 8'd0, 8'd9};
      logic [7:0] vb[3] = '{8'd3, 8'd0, 8'd0};
      for (int i = 0; i < 3; i++) begin
         hold(va[i], vb[i]);
         checks++;
         if (c !== 8'hFF) begin
            errors++;
            $display("FAIL saturate %0d/%0d: C=%h required=ff", va[i], vb[i], c);
         end else $display("saturate %0d/%0d: C=%h ok", va[i], vb[i], c);
      end
   endtask

   task automatic test_correction();
      hold(8'd0, 8'd5);
      checks++;
      if (c !== 8'h00) begin
         errors++;
         $display("FAIL correction 0/5: C=%h required=00", c);
      end else $display("correction 0/5: C=%h ok", c);
   endtask

   task automatic test_back_to_back();
      logic [7:0] va[4] = '{8'd7, 8'd49, 8'd100, 8'd0};
      logic [7:0] vb[4] = '{8'd49, 8'd49, 8'd3, 8'd5};
      logic [7:0] ve[4] = '{8'h12, 8'h80, 8'hFF, 8'h00};
      for (int n = 0; n < 11; n++) begin
         if (n < 4) begin
            a = va[n];
            b = vb[n];
         end
         @(posedge clk);
         #1;
         if (n >= 7) begin
            checks++;
            if (c !== ve[n-7]) begin
               errors++;
               $display("FAIL stream[%0d]: C=%h required=%h", n-7, c, ve[n-7]);
            end else $display("stream[%0d]: C=%h ok", n-7, c);
         end
      end
   endtask

   task automatic test_reset_midstream();
      logic [7:0] va[8] = '{8'd7, 8'd49, 8'd100, 8'd255, 8'd0, 8'd1, 8'd9, 8'd7};
      logic [7:0] vb[8] = '{8'd49, 8'd49, 8'd3, 8'd200, 8'd5, 8'd255, 8'd0, 8'd49};
      logic [7:0] ve[8] = '{8'h12, 8'h80, 8'hFF, 8'hA3, 8'h00, 8'h00, 8'hFF, 8'h12};
      for (int n = 0; n < 15; n++) begin
         if (n < 8) begin
            a = va[n];
            b = vb[n];
         end
         rst = (n == 3);
         @(posedge clk);
         #1;
         rst = 1'b0;
         if (n == 3) begin
            checks++;
            if (c !== 8'h00) begin
               errors++;
               $display("FAIL midrst_clear: C=%h required=00", c);
            end else $display("midrst_clear: C=%h ok", c);
         end else if (n >= 7 && n <= 10) begin
            checks++;
            if (c === ve[n-7]) begin
               errors++;
               $display("FAIL midrst_flushed[%0d]: C=%h required anything but %h", n-7, c, ve[n-7]);
            end else $display("midrst_flushed[%0d]: C=%h absent ok", n-7, c);
         end else if (n >= 11) begin
            checks++;
            if (c !== ve[n-7]) begin
               errors++;
               $display("FAIL midrst_resume[%0d]: C=%h required=%h", n-7, c, ve[n-7]);
            end else $display("midrst_resume[%0d]: C=%h ok", n-7, c);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [7:0] e;
      int         n_vec = 200;
      for (int n = 0; n < n_vec + 7; n++) begin
         if (n < n_vec) begin
            a = 8'($urandom_range(0, 255));
            b = (($urandom_range(0, 15)) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            exp_q.push_back(ref_div(a, b));
         end
         @(posedge clk);
         #1;
         if (n >= 7) begin
            e = exp_q.pop_front();
            checks++;
            if (c !== e) begin
               errors++;
               $display("FAIL random[%0d]: C=%h required=%h", n-7, c, e);
            end
         end
      end
      $display("random: %0d samples compared", n_vec);
   endtask

   initial begin
      rst = 1'b1;
      a   = 8'd0;
      b   = 8'd0;
      test_reset();
      test_basic();
      test_saturate();
      test_correction();
      test_back_to_back();
      test_reset_midstream();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
